// File: rtl/jogo_sequencia_pkg.sv
// rtl/jogo_sequencia_pkg.sv - state encodings shared by the sequence-game control unit
package jogo_sequencia_pkg;

    typedef enum logic [3:0] {
        IDLE           = 4'h0,
        PREPARACAO     = 4'h1,
        INICIO         = 4'h2,
        ESPERA         = 4'h3,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMA_JOGADA = 4'h6,
        ULTIMA_RODADA  = 4'h7,
        PROXIMA_RODADA = 4'h8,
        FALHA          = 4'h9,
        FIM_A          = 4'hA,
        FIM_T          = 4'hD,
        FIM_E          = 4'hE
    } estado_t;

    localparam logic [3:0] DB_ESTADO_INVALIDO = 4'hF;

endpackage

// File: rtl/contador_m.sv
// rtl/contador_m.sv - modulo-M up-counter with synchronous clear and terminal-count flag
module contador_m #(
    parameter  int M = 16,
    localparam int W = (M > 2) ? $clog2(M) : 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera,
    input  logic         conta,
    output logic [W-1:0] Q,
    output logic         fim
);

    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (zera) begin
            q_d = '0;
        end else if (conta) begin
            q_d = (q_q == W'(M - 1)) ? '0 : q_q + W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q   = q_q;
    assign fim = (q_q == W'(M - 1));

endmodule

// File: rtl/jogo_sequencia_controle.sv
// rtl/jogo_sequencia_controle.sv - Moore control unit for the sequence-memory game
module jogo_sequencia_controle
    import jogo_sequencia_pkg::*;
#(
    parameter  int N_JOGADAS = 16,
    parameter  int TIMEOUT   = 5000,
    parameter  int VIDAS     = 1,
    localparam int W         = (N_JOGADAS > 2) ? $clog2(N_JOGADAS) : 1,
    localparam int WV        = $clog2(VIDAS + 1),
    localparam int WT        = $clog2(TIMEOUT)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          jogar,
    input  logic          modo,
    input  logic          jogada,
    input  logic          jogada_correta,
    output logic [W-1:0]  endereco,
    output logic [W-1:0]  rodada,
    output logic [WV-1:0] vidas,
    output logic          limpaRC,
    output logic          registraRC,
    output logic          zeraLeds,
    output logic          registraLeds,
    output logic          led_selector,
    output logic          ganhou,
    output logic          perdeu,
    output logic          pronto,
    output logic          db_timeout,
    output logic [3:0]    db_estado
);

    estado_t       estado_q, estado_d;
    logic [W-1:0]  endereco_q, endereco_d;
    logic [W-1:0]  rodada_q, rodada_d;
    logic [WV-1:0] vidas_q, vidas_d;
    logic          modo_r_q, modo_r_d;
    logic          causa_t_q, causa_t_d;
    logic [WT-1:0] timer_q;
    logic          timer_fim;
    logic [W-1:0]  limite;

    // Timer only runs while waiting for a play; saturating at the top keeps it from wrapping
    contador_m #(.M(TIMEOUT)) u_timer (
        .clock (clock),
        .reset (reset),
        .zera  (estado_d != ESPERA),
        .conta ((estado_q == ESPERA) && !timer_fim),
        .Q     (timer_q),
        .fim   (timer_fim)
    );

    assign limite = modo_r_q ? W'(N_JOGADAS - 1) : rodada_q;

    always_comb begin
        estado_d     = estado_q;
        endereco_d   = endereco_q;
        rodada_d     = rodada_q;
        vidas_d      = vidas_q;
        modo_r_d     = modo_r_q;
        causa_t_d    = causa_t_q;
        limpaRC      = 1'b0;
        registraRC   = 1'b0;
        zeraLeds     = 1'b0;
        registraLeds = 1'b0;
        led_selector = 1'b0;
        ganhou       = 1'b0;
        perdeu       = 1'b0;
        pronto       = 1'b0;
        db_timeout   = 1'b0;
        db_estado    = estado_q;
        case (estado_q)
            IDLE: begin
                zeraLeds = 1'b1;
                limpaRC  = 1'b1;
                if (jogar) estado_d = PREPARACAO;
            end
            PREPARACAO: begin
                zeraLeds     = 1'b1;
                limpaRC      = 1'b1;
                led_selector = 1'b1;
                rodada_d     = '0;
                endereco_d   = '0;
                vidas_d      = WV'(VIDAS);
                modo_r_d     = modo;
                causa_t_d    = 1'b0;
                estado_d     = INICIO;
            end
            INICIO: begin
                registraLeds = 1'b1;
                led_selector = 1'b1;
                endereco_d   = '0;
                estado_d     = ESPERA;
            end
            ESPERA: begin
                // A play arriving on the expiry cycle still counts
                if (jogada) begin
                    estado_d = REGISTRA;
                end else if (timer_q == WT'(TIMEOUT - 1)) begin
                    estado_d  = FALHA;
                    causa_t_d = 1'b1;
                end
            end
            REGISTRA: begin
                registraRC   = 1'b1;
                registraLeds = 1'b1;
                estado_d     = COMPARACAO;
            end
            COMPARACAO: begin
                if (!jogada_correta) begin
                    estado_d  = FALHA;
                    causa_t_d = 1'b0;
                end else if (endereco_q == limite) begin
                    estado_d = ULTIMA_RODADA;
                end else begin
                    estado_d = PROXIMA_JOGADA;
                end
            end
            PROXIMA_JOGADA: begin
                endereco_d = endereco_q + W'(1);
                estado_d   = ESPERA;
            end
            ULTIMA_RODADA: begin
                if (modo_r_q || rodada_q == W'(N_JOGADAS - 1)) estado_d = FIM_A;
                else                                           estado_d = PROXIMA_RODADA;
            end
            PROXIMA_RODADA: begin
                led_selector = 1'b1;
                rodada_d     = rodada_q + W'(1);
                estado_d     = INICIO;
            end
            FALHA: begin
                // Spare lives replay the same round from its first position
                vidas_d = vidas_q - WV'(1);
                if (vidas_q == WV'(1)) estado_d = causa_t_q ? FIM_T : FIM_E;
                else                   estado_d = INICIO;
            end
            FIM_A: begin
                pronto = 1'b1;
                ganhou = 1'b1;
                if (jogar) estado_d = PREPARACAO;
            end
            FIM_T: begin
                pronto     = 1'b1;
                perdeu     = 1'b1;
                db_timeout = 1'b1;
                if (jogar) estado_d = PREPARACAO;
            end
            FIM_E: begin
                pronto = 1'b1;
                perdeu = 1'b1;
                if (jogar) estado_d = PREPARACAO;
            end
            default: begin
                estado_d  = IDLE;
                db_estado = DB_ESTADO_INVALIDO;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= IDLE;
            endereco_q <= '0;
            rodada_q   <= '0;
            vidas_q    <= WV'(VIDAS);
            modo_r_q   <= 1'b0;
            causa_t_q  <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            rodada_q   <= rodada_d;
            vidas_q    <= vidas_d;
            modo_r_q   <= modo_r_d;
            causa_t_q  <= causa_t_d;
        end
    end

    assign endereco = endereco_q;
    assign rodada   = rodada_q;
    assign vidas    = vidas_q;

endmodule

// File: tb/tb_jogo_sequencia_controle.sv
// tb/tb_jogo_sequencia_controle.sv - directed bench for jogo_sequencia_controle
module tb_jogo_sequencia_controle;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic sel = 1'b0;
    logic jogar = 1'b0, modo = 1'b0, jogada = 1'b0, correta = 1'b0;

    logic [1:0] end_a, rod_a, end_b, rod_b, vid_b;
    logic       vid_a;
    logic [3:0] est_a, est_b;
    logic lim_a, rrc_a, zer_a, rld_a, lsel_a, gan_a, per_a, pro_a, tmo_a;
    logic lim_b, rrc_b, zer_b, rld_b, lsel_b, gan_b, per_b, pro_b, tmo_b;

    jogo_sequencia_controle #(.N_JOGADAS(4), .TIMEOUT(10), .VIDAS(1)) dut_a (
        .clock(clock), .reset(reset),
        .jogar(jogar & ~sel), .modo(modo & ~sel),
        .jogada(jogada & ~sel), .jogada_correta(correta & ~sel),
        .endereco(end_a), .rodada(rod_a), .vidas(vid_a),
        .limpaRC(lim_a), .registraRC(rrc_a), .zeraLeds(zer_a),
        .registraLeds(rld_a), .led_selector(lsel_a),
        .ganhou(gan_a), .perdeu(per_a), .pronto(pro_a), .db_timeout(tmo_a),
        .db_estado(est_a)
    );

    jogo_sequencia_controle #(.N_JOGADAS(4), .TIMEOUT(10), .VIDAS(3)) dut_b (
        .clock(clock), .reset(reset),
        .jogar(jogar & sel), .modo(modo & sel),
        .jogada(jogada & sel), .jogada_correta(correta & sel),
        .endereco(end_b), .rodada(rod_b), .vidas(vid_b),
        .limpaRC(lim_b), .registraRC(rrc_b), .zeraLeds(zer_b),
        .registraLeds(rld_b), .led_selector(lsel_b),
        .ganhou(gan_b), .perdeu(per_b), .pronto(pro_b), .db_timeout(tmo_b),
        .db_estado(est_b)
    );

    logic [3:0] est;
    logic [1:0] ender, rod, vid;
    logic [4:0] stb;
    logic [3:0] flg;
    assign est   = sel ? est_b : est_a;
    assign ender = sel ? end_b : end_a;
    assign rod   = sel ? rod_b : rod_a;
    assign vid   = sel ? vid_b : {1'b0, vid_a};
    assign stb   = sel ? {lim_b, rrc_b, zer_b, rld_b, lsel_b} : {lim_a, rrc_a, zer_a, rld_a, lsel_a};
    assign flg   = sel ? {gan_b, per_b, pro_b, tmo_b} : {gan_a, per_a, pro_a, tmo_a};

    typedef struct {
        logic       jg, md, jd, ok;
        logic [3:0] est;
        logic [1:0] ender, rod, vid;
        logic [4:0] stb;
        logic [3:0] flg;
    } vec_t;

    vec_t tab[17];
    int   n_vec = 0;
    int   n_err = 0;
    logic seen_prox = 1'b0;

    function automatic vec_t v(input logic jg, jd, ok, input logic [3:0] e,
                               input logic [1:0] en, ro, input logic [4:0] s);
        vec_t r;
        r.jg = jg; r.md = 1'b0; r.jd = jd; r.ok = ok;
        r.est = e; r.ender = en; r.rod = ro; r.vid = 2'd1; r.stb = s; r.flg = 4'b0000;
        return r;
    endfunction

    task automatic tick;
        @(posedge clock);
        @(negedge clock);
        if (est == 4'h8) seen_prox = 1'b1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_state(input logic [3:0] s);
        int n = 0;
        while (est !== s && n < 60) begin
            tick;
            n++;
        end
        chk($sformatf("wait_state %0h", s), 32'(est), 32'(s));
    endtask

    task automatic play(input logic ok);
        wait_state(4'h3);
        jogada = 1'b1;
        tick;
        jogada = 1'b0;
        tick;
        correta = ok;
        tick;
        correta = 1'b0;
    endtask

    initial begin
        // {jogar, jogada, correta} -> state, endereco, rodada after the edge
        tab[0]  = v(0, 0, 0, 4'h0, 2'd0, 2'd0, 5'b10100);
        tab[1]  = v(1, 0, 0, 4'h1, 2'd0, 2'd0, 5'b10101);
        tab[2]  = v(0, 0, 0, 4'h2, 2'd0, 2'd0, 5'b00011);
        tab[3]  = v(0, 0, 0, 4'h3, 2'd0, 2'd0, 5'b00000);
        tab[4]  = v(0, 1, 0, 4'h4, 2'd0, 2'd0, 5'b01010);
        tab[5]  = v(0, 0, 0, 4'h5, 2'd0, 2'd0, 5'b00000);
        tab[6]  = v(0, 0, 1, 4'h7, 2'd0, 2'd0, 5'b00000);
        tab[7]  = v(0, 0, 0, 4'h8, 2'd0, 2'd0, 5'b00001);
        tab[8]  = v(0, 0, 0, 4'h2, 2'd0, 2'd1, 5'b00011);
        tab[9]  = v(1, 0, 0, 4'h3, 2'd0, 2'd1, 5'b00000);
        tab[10] = v(0, 1, 0, 4'h4, 2'd0, 2'd1, 5'b01010);
        tab[11] = v(0, 0, 0, 4'h5, 2'd0, 2'd1, 5'b00000);
        tab[12] = v(0, 0, 1, 4'h6, 2'd0, 2'd1, 5'b00000);
        tab[13] = v(0, 0, 0, 4'h3, 2'd1, 2'd1, 5'b00000);
        tab[14] = v(0, 1, 0, 4'h4, 2'd1, 2'd1, 5'b01010);
        tab[15] = v(0, 0, 0, 4'h5, 2'd1, 2'd1, 5'b00000);
        tab[16] = v(0, 0, 1, 4'h7, 2'd1, 2'd1, 5'b00000);

        repeat (2) @(negedge clock);
        chk("reset est", 32'(est), 32'h0);
        chk("reset vid", 32'(vid), 32'd1);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            jogar = tab[i].jg; modo = tab[i].md; jogada = tab[i].jd; correta = tab[i].ok;
            tick;
            chk($sformatf("vec%0d est", i), 32'(est), 32'(tab[i].est));
            chk($sformatf("vec%0d end", i), 32'(ender), 32'(tab[i].ender));
            chk($sformatf("vec%0d rod", i), 32'(rod), 32'(tab[i].rod));
            chk($sformatf("vec%0d vid", i), 32'(vid), 32'(tab[i].vid));
            chk($sformatf("vec%0d stb", i), 32'(stb), 32'(tab[i].stb));
            chk($sformatf("vec%0d flg", i), 32'(flg), 32'(tab[i].flg));
        end
        jogar = 1'b0; jogada = 1'b0; correta = 1'b0;

        // Finish growing game: rounds 2 and 3
        for (int i = 0; i < 7; i++) play(1'b1);
        wait_state(4'hA);
        chk("winA flg", 32'(flg), 32'b1010);
        chk("winA rod", 32'(rod), 32'd3);

        // Miss at rodada 2, endereco 1 with a single life
        jogar = 1'b1; tick; jogar = 1'b0;
        chk("restart est", 32'(est), 32'h1);
        for (int i = 0; i < 4; i++) play(1'b1);
        play(1'b0);
        chk("missE falha", 32'(est), 32'h9);
        tick;
        chk("missE est", 32'(est), 32'hE);
        chk("missE flg", 32'(flg), 32'b0110);
        chk("missE vid", 32'(vid), 32'd0);
        chk("missE rod", 32'(rod), 32'd2);
        chk("missE end", 32'(ender), 32'd1);
        tick;
        chk("fimE hold", 32'(est), 32'hE);

        // Restart after fim_E, then let the timer expire
        jogar = 1'b1; tick; jogar = 1'b0; tick;
        chk("reinicio est", 32'(est), 32'h2);
        chk("reinicio vid", 32'(vid), 32'd1);
        chk("reinicio rod", 32'(rod), 32'd0);
        wait_state(4'h3);
        repeat (9) tick;
        chk("tmo pre", 32'(est), 32'h3);
        tick;
        chk("tmo falha", 32'(est), 32'h9);
        tick;
        chk("tmo est", 32'(est), 32'hD);
        chk("tmo flg", 32'(flg), 32'b0111);

        // Play on the last allowed cycle wins over expiry
        jogar = 1'b1; tick; jogar = 1'b0;
        wait_state(4'h3);
        repeat (9) tick;
        jogada = 1'b1; tick; jogada = 1'b0;
        chk("edge play est", 32'(est), 32'h4);
        chk("edge play flg", 32'(flg), 32'b0000);
        tick;
        correta = 1'b1; tick; correta = 1'b0;
        wait_state(4'h3);
        chk("pre-reset rod", 32'(rod), 32'd1);

        // Asynchronous reset between edges
        #2 reset = 1'b1;
        #1;
        chk("async est", 32'(est), 32'h0);
        chk("async stb", 32'(stb), 32'b10100);
        chk("async rod", 32'(rod), 32'd0);
        #1 reset = 1'b0;
        @(negedge clock);

        // Full-sequence mode, modo dropped mid-game
        modo = 1'b1; jogar = 1'b1; tick; jogar = 1'b0; tick;
        modo = 1'b0;
        seen_prox = 1'b0;
        for (int i = 0; i < 4; i++) play(1'b1);
        wait_state(4'hA);
        chk("modo1 rod", 32'(rod), 32'd0);
        chk("modo1 end", 32'(ender), 32'd3);
        chk("modo1 flg", 32'(flg), 32'b1010);
        chk("modo1 no prox", 32'(seen_prox), 32'd0);

        // Three lives: miss in round 1 replays it
        sel = 1'b1;
        @(negedge clock);
        jogar = 1'b1; tick; jogar = 1'b0;
        play(1'b1);
        play(1'b0);
        chk("vidas falha", 32'(est), 32'h9);
        chk("vidas pre", 32'(vid), 32'd3);
        tick;
        chk("replay est", 32'(est), 32'h2);
        chk("replay vid", 32'(vid), 32'd2);
        chk("replay rod", 32'(rod), 32'd1);
        chk("replay end", 32'(ender), 32'd0);
        for (int i = 0; i < 9; i++) play(1'b1);
        wait_state(4'hA);
        chk("vidas win vid", 32'(vid), 32'd2);
        chk("vidas win flg", 32'(flg), 32'b1010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/jogo_sequencia_controle.md
Name: jogo_sequencia_controle

Overview:
Parametrised control unit for the sequence-memory game. It drives the sequence RAM/register/LED datapath and owns the round, position, timeout and lives counters internally, so the datapath no longer supplies `fim`, `enderecoIgualRodada` or `timeout`. New behaviour over the previous generation:
- configurable sequence length and timeout;
- multiple lives, with replay of the current round after a miss;
- a single-round "full sequence" mode.

It sits between the top-level game wrapper and the datapath.

Parameters:
- N_JOGADAS, 16: sequence length and number of rounds; legal range ≥2.
- TIMEOUT, 5000: clock cycles allowed in `espera` per play; legal range ≥2.
- VIDAS, 1: lives per game; legal range ≥1. VIDAS=1 gives the previous generation's behaviour.
- Derived: W = max(1, $clog2(N_JOGADAS)); WV = $clog2(VIDAS+1); WT = $clog2(TIMEOUT).

Ports:
- clock  in  1  system clock
- reset  in  1  reset; asynchronous, active-high
- jogar  in  1  start/restart request (level, sampled each clock)
- modo  in  1  0 = growing rounds; 1 = single round of the full sequence. Sampled only in `preparacao`.
- jogada  in  1  single-cycle pulse: player made a play
- jogada_correta  in  1  datapath compare result, valid in `comparacao`
- endereco  out  W  sequence memory address (position counter)
- rodada  out  W  current round index
- vidas  out  WV  remaining lives
- limpaRC, registraRC, zeraLeds, registraLeds, led_selector  out  1  datapath strobes
- ganhou, perdeu, pronto, db_timeout  out  1  result flags
- db_estado  out  4  state code

Behaviour:
- Moore FSM. All strobes/flags are combinational decodes of the state register. Counters are registered and all change on the same clock edge as the state.
- Reset (async) values: state idle; endereco=0, rodada=0, timer=0, vidas=VIDAS, modo_r=0, causa_t=0.
- Outputs in idle: zeraLeds=1, limpaRC=1; all other flags 0; db_estado=0.
- State codes, transitions and actions:
  - idle 0: jogar → preparacao.
  - preparacao 1: rodada←0, endereco←0, vidas←VIDAS, modo_r←modo, causa_t←0 → inicio.
  - inicio 2: endereco←0 → espera.
  - espera 3:
    - timer increments each cycle; timer is held at 0 in every other state.
    - jogada → registra. jogada wins if it coincides with expiry.
    - else if timer==TIMEOUT-1 → falha with causa_t←1.
  - registra 4 → comparacao.
  - comparacao 5:
    - !jogada_correta → falha with causa_t←0;
    - else if endereco==limite → ultima_rodada;
    - else → proxima_jogada.
    - limite = modo_r ? N_JOGADAS-1 : rodada.
  - proxima_jogada 6: endereco←endereco+1 → espera.
  - ultima_rodada 7: (modo_r || rodada==N_JOGADAS-1) → fim_A; else → proxima_rodada.
  - proxima_rodada 8: rodada←rodada+1 → inicio.
  - falha 9: vidas←vidas-1.
    - If vidas==1 before decrement → causa_t ? fim_T : fim_E.
    - Else → inicio, replaying the same rodada from endereco 0.
  - fim_A A, fim_T D, fim_E E: hold all counters; jogar → preparacao.
  - Unused codes → idle, db_estado=F.
- Strobe decodes:
  - zeraLeds, limpaRC: idle, preparacao.
  - registraRC: registra.
  - registraLeds: inicio, registra.
  - led_selector: preparacao, inicio, proxima_rodada.
- Flag decodes:
  - pronto: fim_A, fim_T, fim_E.
  - ganhou: fim_A.
  - perdeu: fim_T, fim_E.
  - db_timeout: fim_T.
- Counters never wrap in legal operation: rodada and endereco are bounded by N_JOGADAS-1 through the FSM. vidas never underflows.
- jogar outside idle and fim states is ignored. modo changes mid-game have no effect.
- Reset mid-game: immediate return to idle and reset values, independent of clock.

Decomposition:
- Package jogo_sequencia_pkg: 4-bit state encodings (values above) and the db_estado default F.
- One sub-module, contador_m: parametrised up-counter (M, zera, conta, Q, fim). Used for the timeout timer. rodada, endereco and vidas stay inline.

Test Plan:
- N_JOGADAS=4, VIDAS=1, modo=0, all correct: rounds 0..3 played with 1,2,3,4 jogadas → fim_A; ganhou=pronto=1, db_estado=A, rodada=3.
- Same config, wrong play at rodada=2, endereco=1 → falha then fim_E; perdeu=1, db_estado=E, vidas=0, rodada/endereco hold 2/1.
- VIDAS=3, one wrong play at rodada=1 → falha with vidas=2, then inicio with rodada=1 and endereco=0. Then correct plays → game proceeds to fim_A with vidas=2.
- TIMEOUT=10: no jogada for 10 cycles in espera → fim_T, db_timeout=1. Repeat with jogada on the cycle timer==9 → registra, no timeout.
- modo=1, N_JOGADAS=4: 4 correct plays in one round → fim_A with rodada=0 and no proxima_rodada visited. modo toggled mid-game has no effect.
- Reset pulse mid-espera (async, between edges) → outputs at idle values immediately; jogar after fim_E restarts with vidas=VIDAS, rodada=0.
